// File: rtl/regfile_2r1w_clr.sv
// Two-read / one-write register file with write-first bypass and a hardware
// clear sweep that runs after reset and on request.
module regfile_2r1w_clr #(
    parameter int                 DATA_W  = 8,
    parameter int                 ADDR_W  = 4,
    parameter logic [DATA_W-1:0]  CLR_VAL = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    output logic              busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    output logic              rd_valid_a,
    input  logic              rd_en_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_valid_b
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    logic [DATA_W-1:0]   rd_data_a_q, rd_data_a_d;
    logic [DATA_W-1:0]   rd_data_b_q, rd_data_b_d;
    logic                rd_valid_a_q, rd_valid_a_d;
    logic                rd_valid_b_q, rd_valid_b_d;

    // busy is the FSM state itself, so it stays high while reset is held.
    assign busy       = (state_q == CLEAR);
    assign rd_data_a  = rd_data_a_q;
    assign rd_data_b  = rd_data_b_q;
    assign rd_valid_a = rd_valid_a_q;
    assign rd_valid_b = rd_valid_b_q;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        mem_we       = 1'b0;
        mem_waddr    = wr_addr;
        mem_wdata    = wr_data;
        rd_data_a_d  = rd_data_a_q;
        rd_data_b_d  = rd_data_b_q;
        rd_valid_a_d = 1'b0;
        rd_valid_b_d = 1'b0;

        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
                mem_wdata = CLR_VAL;
                ptr_d     = ptr_q + 1'b1;
                if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end
            end
            default: begin
                // A clear request drops any write or read issued in the same cycle.
                if (clear) begin
                    state_d = CLEAR;
                end else begin
                    mem_we = wr_en;
                    if (rd_en_a) begin
                        rd_valid_a_d = 1'b1;
                        rd_data_a_d  = (wr_en && (wr_addr == rd_addr_a)) ? wr_data
                                                                         : mem_q[rd_addr_a];
                    end
                    if (rd_en_b) begin
                        rd_valid_b_d = 1'b1;
                        rd_data_b_d  = (wr_en && (wr_addr == rd_addr_b)) ? wr_data
                                                                         : mem_q[rd_addr_b];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= CLEAR;
            ptr_q        <= '0;
            rd_data_a_q  <= '0;
            rd_data_b_q  <= '0;
            rd_valid_a_q <= 1'b0;
            rd_valid_b_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            rd_data_a_q  <= rd_data_a_d;
            rd_data_b_q  <= rd_data_b_d;
            rd_valid_a_q <= rd_valid_a_d;
            rd_valid_b_q <= rd_valid_b_d;
        end
    end

    // Storage has no reset; the sweep is what initialises it.
    always_ff @(posedge clock) begin
        if (reset_n && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_regfile_2r1w_clr.sv
// Directed bench for regfile_2r1w_clr: reset sweep, read/write, bypass, hold,
// commanded clear and reset in the middle of a sweep.
module tb_regfile_2r1w_clr;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic              clock;
    logic              reset_n;
    logic              clear;
    logic              busy;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en_a;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [DATA_W-1:0] rd_data_a;
    logic              rd_valid_a;
    logic              rd_en_b;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_b;
    logic              rd_valid_b;

    int tests_run;
    int tests_failed;

    regfile_2r1w_clr #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .CLR_VAL(8'h00)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (clear),
        .busy      (busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en_a   (rd_en_a),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_valid_a(rd_valid_a),
        .rd_en_b   (rd_en_b),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b),
        .rd_valid_b(rd_valid_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        clear     = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_en_a   = 1'b0;
        rd_addr_a = '0;
        rd_en_b   = 1'b0;
        rd_addr_b = '0;
    endtask

    // Counts cycles with busy=1 from now, bounded so the bench cannot hang.
    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 64; i++) begin
            if (!busy) break;
            n++;
            tick();
        end
    endtask

    task automatic write_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic fill_all(input logic [DATA_W-1:0] d);
        for (int i = 0; i < DEPTH; i++) write_word(ADDR_W'(i), d);
    endtask

    // Reads every entry through both ports (A ascending, B descending).
    task automatic check_all(input string tag, input logic [DATA_W-1:0] exp);
        for (int i = 0; i < DEPTH; i++) begin
            rd_en_a   = 1'b1;
            rd_addr_a = ADDR_W'(i);
            rd_en_b   = 1'b1;
            rd_addr_b = ADDR_W'(DEPTH - 1 - i);
            tick();
            rd_en_a = 1'b0;
            rd_en_b = 1'b0;
            tests_run++;
            if (rd_valid_a !== 1'b1 || rd_data_a !== exp) begin
                tests_failed++;
                $display("FAIL %s_a[%0d]: got valid=%b data=%h, expected valid=1 data=%h",
                         tag, i, rd_valid_a, rd_data_a, exp);
            end
            tests_run++;
            if (rd_valid_b !== 1'b1 || rd_data_b !== exp) begin
                tests_failed++;
                $display("FAIL %s_b[%0d]: got valid=%b data=%h, expected valid=1 data=%h",
                         tag, DEPTH - 1 - i, rd_valid_b, rd_data_b, exp);
            end
        end
    endtask

    task automatic test_reset();
        int n;
        idle_inputs();
        reset_n = 1'b0;
        tick();
        tick();
        tests_run++;
        if (busy !== 1'b1 || rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0 ||
            rd_data_a !== 8'h00 || rd_data_b !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_state: got busy=%b va=%b vb=%b da=%h db=%h, expected 1 0 0 00 00",
                     busy, rd_valid_a, rd_valid_b, rd_data_a, rd_data_b);
        end
        reset_n = 1'b1;
        count_busy(n);
        tests_run++;
        if (n !== 16) begin
            tests_failed++;
            $display("FAIL reset_busy_len: got %0d cycles, expected 16", n);
        end
        check_all("reset_sweep", 8'h00);
    endtask

    task automatic test_write_read();
        write_word(4'd3, 8'hA5);
        write_word(4'd12, 8'h5A);
        rd_en_a = 1'b1; rd_addr_a = 4'd3;
        rd_en_b = 1'b1; rd_addr_b = 4'd12;
        tick();
        rd_en_a = 1'b0; rd_en_b = 1'b0;
        tests_run++;
        if (rd_valid_a !== 1'b1 || rd_data_a !== 8'hA5 || rd_valid_b !== 1'b1 || rd_data_b !== 8'h5A) begin
            tests_failed++;
            $display("FAIL write_read: got va=%b da=%h vb=%b db=%h, expected 1 a5 1 5a",
                     rd_valid_a, rd_data_a, rd_valid_b, rd_data_b);
        end
        rd_en_a = 1'b1; rd_addr_a = 4'd12;
        rd_en_b = 1'b1; rd_addr_b = 4'd12;
        tick();
        rd_en_a = 1'b0; rd_en_b = 1'b0;
        tests_run++;
        if (rd_data_a !== 8'h5A || rd_data_b !== 8'h5A || rd_valid_a !== 1'b1 || rd_valid_b !== 1'b1) begin
            tests_failed++;
            $display("FAIL same_addr: got da=%h db=%h, expected 5a 5a", rd_data_a, rd_data_b);
        end
    endtask

    task automatic test_bypass();
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 8'h3C;
        rd_en_a = 1'b1; rd_addr_a = 4'd7;
        rd_en_b = 1'b1; rd_addr_b = 4'd8;
        tick();
        idle_inputs();
        tests_run++;
        if (rd_data_a !== 8'h3C || rd_valid_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL bypass_a: got %h, expected 3c", rd_data_a);
        end
        tests_run++;
        if (rd_data_b !== 8'h00 || rd_valid_b !== 1'b1) begin
            tests_failed++;
            $display("FAIL bypass_b_old: got %h, expected 00", rd_data_b);
        end
        rd_en_b = 1'b1; rd_addr_b = 4'd7;
        tick();
        rd_en_b = 1'b0;
        tests_run++;
        if (rd_data_b !== 8'h3C) begin
            tests_failed++;
            $display("FAIL bypass_stored: got %h, expected 3c", rd_data_b);
        end
    endtask

    task automatic test_hold();
        rd_en_a = 1'b1; rd_addr_a = 4'd3;
        tick();
        rd_en_a = 1'b0;
        tests_run++;
        if (rd_data_a !== 8'hA5 || rd_valid_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL hold_read: got valid=%b data=%h, expected 1 a5", rd_valid_a, rd_data_a);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (rd_valid_a !== 1'b0 || rd_data_a !== 8'hA5) begin
                tests_failed++;
                $display("FAIL hold_cycle%0d: got valid=%b data=%h, expected 0 a5", i, rd_valid_a, rd_data_a);
            end
        end
    endtask

    task automatic test_clear();
        int n;
        fill_all(8'hFF);
        clear = 1'b1;
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'h11;
        rd_en_a = 1'b1; rd_addr_a = 4'd5;
        tick();
        idle_inputs();
        tests_run++;
        if (busy !== 1'b1 || rd_valid_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_start: got busy=%b va=%b, expected 1 0", busy, rd_valid_a);
        end
        rd_en_a = 1'b1; rd_addr_a = 4'd2;
        rd_en_b = 1'b1; rd_addr_b = 4'd9;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            if (!busy) break;
            n++;
            tick();
            if (busy) begin
                tests_run++;
                if (rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL clear_rd_valid: got va=%b vb=%b, expected 0 0", rd_valid_a, rd_valid_b);
                end
            end
        end
        idle_inputs();
        tests_run++;
        if (n !== 16) begin
            tests_failed++;
            $display("FAIL clear_busy_len: got %0d cycles, expected 16", n);
        end
        check_all("after_clear", 8'h00);
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        fill_all(8'h77);
        rd_en_a = 1'b1; rd_addr_a = 4'd0;
        tick();
        rd_en_a = 1'b0;
        tests_run++;
        if (rd_data_a !== 8'h77) begin
            tests_failed++;
            $display("FAIL mid_pre_read: got %h, expected 77", rd_data_a);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        reset_n = 1'b0;
        tick();
        tests_run++;
        if (busy !== 1'b1 || rd_data_a !== 8'h00) begin
            tests_failed++;
            $display("FAIL mid_reset: got busy=%b da=%h, expected 1 00", busy, rd_data_a);
        end
        reset_n = 1'b1;
        count_busy(n);
        tests_run++;
        if (n !== 16) begin
            tests_failed++;
            $display("FAIL mid_busy_len: got %0d cycles, expected 16", n);
        end
        check_all("mid_sweep", 8'h00);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_n      = 1'b0;
        idle_inputs();
        test_reset();
        test_write_read();
        test_bypass();
        test_hold();
        test_clear();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/regfile_2r1w_clr.md
Name: regfile_2r1w_clr

Overview:
- Parametrised register file: one synchronous write port, two independent registered read ports (A/B).
- Write-first bypass on same-address collisions.
- Hardware clear sequencer sweeps every entry to a programmable value after reset or on command.
- Drop-in successor to the single-port 16x8 register file; used by the datapath and the display/control logic that needs two operands per cycle.

Parameters:
- DATA_W, 8, data width in bits (>=1).
- ADDR_W, 4, address width in bits; depth DEPTH = 2**ADDR_W is a derived localparam, not overridable.
- CLR_VAL, 0, value (DATA_W bits) written to every entry by the clear sweep.

Ports:
- clock  input  1  single clock; all state changes on rising edge.
- reset_n  input  1  reset, synchronous, active-low.
- clear  input  1  request clear sweep (single-cycle pulse or level; sampled only in IDLE).
- busy  output  1  high while the clear sweep runs (state CLEAR).
- wr_en  input  1  write strobe.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  DATA_W  write data.
- rd_en_a  input  1  read request, port A.
- rd_addr_a  input  ADDR_W  read address, port A.
- rd_data_a  output  DATA_W  registered read data, port A.
- rd_valid_a  output  1  rd_data_a updated this cycle.
- rd_en_b, rd_addr_b, rd_data_b, rd_valid_b: identical to port A, for port B.

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset (reset_n=0 at an edge):
  - state<=CLEAR, sweep pointer<=0.
  - rd_data_a/b<=0, rd_valid_a/b<=0.
  - busy=1 combinationally from state, so busy reads 1 while reset is held.
  - Storage array contents are not touched by reset itself.
- FSM, two states: IDLE, CLEAR.
- CLEAR:
  - Each edge writes CLR_VAL to mem[ptr], then ptr<=ptr+1.
  - After the edge writing entry DEPTH-1: state<=IDLE, ptr<=0.
  - Sweep takes exactly DEPTH edges after reset release (DEPTH=16: busy high 16 cycles, then 0).
  - wr_en, rd_en_a/b and clear are ignored; rd_valid_a/b<=0; rd_data_a/b hold their values.
- IDLE, clear=1:
  - state<=CLEAR next edge; busy rises the following cycle.
  - Any same-cycle write and reads are dropped (clear has priority); rd_valid<=0.
- IDLE, clear=0, write path:
  - wr_en=1: mem[wr_addr]<=wr_data at the edge.
- IDLE, clear=0, read path (per port, independent):
  - rd_en=1: at the edge, rd_data<=mem[rd_addr] and rd_valid<=1. One-cycle latency: data is valid in the cycle after the request.
  - Bypass: if wr_en=1 and wr_addr==rd_addr in the same cycle, rd_data<=wr_data (write-first, new data).
  - rd_en=0: rd_valid<=0; rd_data holds its last value (never forced to 0).
- Ports A and B may read the same address in the same cycle; both return identical data.
- Reset mid-sweep restarts the sweep from entry 0 after release.
- Address arithmetic is modulo DEPTH; no out-of-range addresses exist.
- No overflow or underflow conditions; writes every cycle are legal.

Test Plan:
- Reset release -> busy=1 for exactly 16 cycles, then 0. Afterwards, reads of addr 0..15 all return CLR_VAL=0x00 with rd_valid=1 one cycle after each rd_en.
- IDLE: write 0xA5 @3 then 0x5A @12; next cycle read A@3, B@12 -> rd_data_a=0xA5, rd_data_b=0x5A, both valid.
- Same cycle: wr_en=1 wr_addr=7 wr_data=0x3C, rd_en_a=1 rd_addr_a=7 -> next cycle rd_data_a=0x3C (bypass). rd_en_b=1 rd_addr_b=8 in the same cycle -> rd_data_b returns the old mem[8].
- Read A@3 (0xA5), then rd_en_a=0 for 3 cycles -> rd_valid_a=0 each cycle, rd_data_a stays 0xA5.
- Fill all entries with 0xFF; pulse clear together with wr_en @2 = 0x11 -> busy=1 for 16 cycles, write dropped. Reads during busy give rd_valid=0; all entries read 0x00 afterwards.
- Assert reset_n=0 at sweep cycle 5, release -> busy high 16 more cycles from release; all entries read CLR_VAL.
